bus_matrix: RTL and testbench
=============================

Name: bus_matrix

Overview:
- Parametrised successor to the shared-bus arbiter/decoder: N masters, M slaves, configurable widths.
- Round-robin arbitration replaces fixed ordering.
- Direct owner-to-owner handover with no idle cycle between owners.
- Sits between CPU/DMA masters and ROM/GPIO/RAM slaves in the top-level processor.

Parameters:
- NUM_MASTERS, 4, number of bus masters (2..8).
- NUM_SLAVES, 8, number of slaves; must be <= 2**SEL_W.
- ADDR_W, 30, word address width.
- DATA_W, 32, data width.
- SEL_W, 3, top address bits used as slave index.
- OWN_W, 2, width of owner index; must be >= clog2(NUM_MASTERS).
- TIMEOUT_CYCLES, 256, wait limit used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mReq_  in  NUM_MASTERS  per-master bus request, active-low.
- mGrnt_  out  NUM_MASTERS  per-master grant, active-low, registered.
- mAddr  in  NUM_MASTERS*ADDR_W  flattened master addresses; master i at [i*ADDR_W +: ADDR_W].
- mAs_  in  NUM_MASTERS  address strobe, active-low.
- mRW  in  NUM_MASTERS  1 = read, 0 = write.
- mWrData  in  NUM_MASTERS*DATA_W  flattened write data.
- mRdData  out  DATA_W  read data returned to the owner.
- mRdy_  out  1  ready returned to the owner, active-low.
- sAddr  out  ADDR_W  shared slave address.
- sAs_  out  1  shared address strobe.
- sRW  out  1  shared read/write.
- sWrData  out  DATA_W  shared write data.
- sCS_  out  NUM_SLAVES  slave chip selects, active-low.
- sRdData  in  NUM_SLAVES*DATA_W  flattened slave read data.
- sRdy_  in  NUM_SLAVES  slave ready, active-low.
- owner  out  OWN_W  current owner index; valid only when busy = 1.
- busy  out  1  a master currently holds the bus.
- busErr  out  1  one-cycle timeout error pulse.

Behaviour:
- Reset values: state IDLE; lastOwner = NUM_MASTERS-1, so master 0 has first priority; mGrnt_ all ones; busy = 0; owner = 0; busErr = 0; timeout counter = 0.
- Reset is asynchronous: asserting reset mid-transfer drops every grant immediately.
- Arbiter has two states, IDLE and OWNED. Winner = first master with mReq_ = 0, searched from (lastOwner+1) mod NUM_MASTERS with wrap-around.
- IDLE: if any mReq_ is low, register the winner as owner → OWNED; mGrnt_ goes low 1 cycle after the request is seen. If no request, stay in IDLE.
- OWNED: while mReq_[owner] = 0, hold the grant. There is no preemption.
- OWNED, owner releases (mReq_ high) with others requesting: the winner, computed excluding the old owner, is granted at the same edge. No all-high grant cycle occurs. lastOwner is updated to the old owner.
- OWNED, owner releases with no other requests: → IDLE, all grants high.
- Shared outputs, combinational from the registered owner:
  - OWNED: sAddr/sAs_/sRW/sWrData = owner's signals.
  - IDLE: sAddr = 0, sAs_ = 1, sRW = 1, sWrData = 0.
- Decode: idx = sAddr[ADDR_W-1 -: SEL_W]. sCS_[i] = 0 iff busy, sAs_ = 0 and idx == i.
- Unmapped idx (>= NUM_SLAVES): no chip select is asserted and mRdy_ stays high.
- Return path, combinational: mRdData = sRdData[idx] and mRdy_ = sRdy_[idx] when busy with a mapped idx; otherwise mRdData = 0 and mRdy_ = 1.
- busErr is tied to 0 when the timeout feature is absent.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- When defined, the timeout counter:
  - increments each cycle while busy, sAs_ = 0 and the selected mRdy_ = 1;
  - clears on mRdy_ low, sAs_ high, or an owner change.
- When the counter reaches TIMEOUT_CYCLES-1, on the following cycle:
  - mRdy_ is forced 0 and mRdData is forced all ones, both for exactly 1 cycle;
  - busErr pulses 1 for that cycle;
  - the counter clears.
- The timeout also covers unmapped indices.
- When undefined: no counter; an unresponsive slave stalls the owner indefinitely; busErr = 0.

Test Plan:
- Reset asserted, then released with no requests → mGrnt_ = 4'b1111, sCS_ = 8'hFF, sAs_ = 1, mRdy_ = 1, busy = 0.
- Master 1 drops mReq_ → next edge mGrnt_ = 4'b1101, owner = 1. Master 1 then drives mAddr = 30'h2000_0004 with mAs_ = 0 → sCS_ = 8'b1110_1111, sAddr = 30'h2000_0004.
- All four masters request from reset → grant order 0,1,2,3,0. Each owner holds for 3 cycles, then releases for 1 cycle. Grants are never simultaneous.
- Owner 0 releases while master 3 is requesting → mGrnt_ goes from 4'b1110 directly to 4'b0111 at one edge, with no 4'b1111 cycle in between.
- Slave 4 drives sRdData = 32'h0000_00A5 with sRdy_[4] = 0 while the owner reads index 4 → same cycle mRdData = 32'h0000_00A5, mRdy_ = 0.
- With BUS_TIMEOUT_EN, owner reads index 5 and sRdy_[5] is held high → after 256 wait cycles: mRdy_ = 0, mRdData = 32'hFFFF_FFFF, busErr = 1, each for exactly 1 cycle. Without the macro, mRdy_ stays 1 for more than 1000 cycles.

Source files
------------

// File: rtl/bus_matrix.sv
// bus_matrix: N-master / M-slave shared bus with round-robin arbitration and
// direct owner-to-owner handover. Define BUS_TIMEOUT_EN to add the slave-wait timeout.
module bus_matrix #(
    parameter int NUM_MASTERS    = 4,
    parameter int NUM_SLAVES     = 8,
    parameter int ADDR_W         = 30,
    parameter int DATA_W         = 32,
    parameter int SEL_W          = 3,
    parameter int OWN_W          = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        mReq_,
    output logic [NUM_MASTERS-1:0]        mGrnt_,
    input  logic [NUM_MASTERS*ADDR_W-1:0] mAddr,
    input  logic [NUM_MASTERS-1:0]        mAs_,
    input  logic [NUM_MASTERS-1:0]        mRW,
    input  logic [NUM_MASTERS*DATA_W-1:0] mWrData,
    output logic [DATA_W-1:0]             mRdData,
    output logic                          mRdy_,
    output logic [ADDR_W-1:0]             sAddr,
    output logic                          sAs_,
    output logic                          sRW,
    output logic [DATA_W-1:0]             sWrData,
    output logic [NUM_SLAVES-1:0]         sCS_,
    input  logic [NUM_SLAVES*DATA_W-1:0]  sRdData,
    input  logic [NUM_SLAVES-1:0]         sRdy_,
    output logic [OWN_W-1:0]              owner,
    output logic                          busy,
    output logic                          busErr
);
    localparam int OWNERS = 1 << OWN_W;
    localparam int SLOTS  = 1 << SEL_W;
    localparam logic [OWN_W:0] NM = (OWN_W+1)'(NUM_MASTERS);
    localparam logic [SEL_W:0] NS = (SEL_W+1)'(NUM_SLAVES);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 state, state_d;
    logic [OWN_W-1:0]       owner_q, owner_d, last_q, last_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;

    // Padded per-master / per-slave views so a full-width index never runs off the end.
    logic [OWNERS-1:0] req_n, as_n, rw;
    logic [ADDR_W-1:0] addr_tab  [OWNERS];
    logic [DATA_W-1:0] wdata_tab [OWNERS];
    logic [DATA_W-1:0] rdata_tab [SLOTS];
    logic [SLOTS-1:0]  rdy_n_tab;

    for (genvar i = 0; i < OWNERS; i++) begin : g_mst
        if (i < NUM_MASTERS) begin : g_real
            assign req_n[i]     = mReq_[i];
            assign as_n[i]      = mAs_[i];
            assign rw[i]        = mRW[i];
            assign addr_tab[i]  = mAddr[i*ADDR_W +: ADDR_W];
            assign wdata_tab[i] = mWrData[i*DATA_W +: DATA_W];
        end else begin : g_pad
            assign req_n[i]     = 1'b1;
            assign as_n[i]      = 1'b1;
            assign rw[i]        = 1'b1;
            assign addr_tab[i]  = '0;
            assign wdata_tab[i] = '0;
        end
    end

    for (genvar j = 0; j < SLOTS; j++) begin : g_slv
        if (j < NUM_SLAVES) begin : g_real
            assign rdata_tab[j] = sRdData[j*DATA_W +: DATA_W];
            assign rdy_n_tab[j] = sRdy_[j];
        end else begin : g_pad
            assign rdata_tab[j] = '0;
            assign rdy_n_tab[j] = 1'b1;
        end
    end

    // Round-robin search: while owned, start just past the current owner (it becomes
    // lastOwner at the handover edge) and skip it; when idle, start past lastOwner.
    logic             win_found;
    logic [OWN_W-1:0] win_idx, base;
    logic [OWN_W:0]   cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        base      = (state == OWNED) ? owner_q : last_q;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = {1'b0, base} + (OWN_W+1)'(k);
            if (cand >= NM) cand = cand - NM;
            if (!win_found && !req_n[cand[OWN_W-1:0]] &&
                !(state == OWNED && cand[OWN_W-1:0] == owner_q)) begin
                win_found = 1'b1;
                win_idx   = cand[OWN_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner_q;
        last_d  = last_q;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_d = OWNED;
                    owner_d = win_idx;
                end
            end
            OWNED: begin
                if (req_n[owner_q]) begin
                    last_d = owner_q;
                    if (win_found) begin
                        owner_d = win_idx;
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = '1;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (state_d == OWNED && owner_d == OWN_W'(i)) grant_d[i] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner_q <= '0;
            last_q  <= OWN_W'(NUM_MASTERS - 1);
            grant_q <= '1;
        end else begin
            state   <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    assign mGrnt_ = grant_q;
    assign owner  = owner_q;
    assign busy   = (state == OWNED);

    assign sAddr   = busy ? addr_tab[owner_q]  : '0;
    assign sAs_    = busy ? as_n[owner_q]      : 1'b1;
    assign sRW     = busy ? rw[owner_q]        : 1'b1;
    assign sWrData = busy ? wdata_tab[owner_q] : '0;

    logic [SEL_W-1:0]  idx;
    logic              mapped;
    logic [DATA_W-1:0] sel_data;
    logic              sel_rdy_n;

    assign idx    = sAddr[ADDR_W-1 -: SEL_W];
    assign mapped = ({1'b0, idx} < NS);

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_cs
        assign sCS_[i] = !(busy && !sAs_ && idx == SEL_W'(i));
    end

    assign sel_data  = (busy && mapped) ? rdata_tab[idx] : '0;
    assign sel_rdy_n = (busy && mapped) ? rdy_n_tab[idx] : 1'b1;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             owner_chg;

    assign owner_chg = (state_d != state) || (owner_d != owner_q);

    // err_q is the one-cycle forced-ready slot; it also restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (owner_chg || !busy || sAs_ || !sel_rdy_n || err_q) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (wait_cnt == LIMIT) begin
            wait_cnt <= '0;
            err_q    <= 1'b1;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            err_q    <= 1'b0;
        end
    end

    assign mRdy_   = sel_rdy_n & ~err_q;
    assign mRdData = err_q ? '1 : sel_data;
    assign busErr  = err_q;
`else
    assign mRdy_   = sel_rdy_n;
    assign mRdData = sel_data;
    assign busErr  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_matrix.sv
// tb_bus_matrix: scoreboard bench for bus_matrix (grants, handover, decode, return, timeout).
module tb_bus_matrix;
    localparam int NM = 4, NS = 8, AW = 30, DW = 32, SW = 3, OW = 2, TO = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic [NM-1:0] mReq_, mGrnt_, mAs_, mRW;
    logic [NM*AW-1:0] mAddr;
    logic [NM*DW-1:0] mWrData;
    logic [DW-1:0] mRdData;
    logic          mRdy_;
    logic [AW-1:0] sAddr;
    logic          sAs_, sRW;
    logic [DW-1:0] sWrData;
    logic [NS-1:0] sCS_;
    logic [NS*DW-1:0] sRdData;
    logic [NS-1:0] sRdy_;
    logic [OW-1:0] owner;
    logic          busy, busErr;

    bus_matrix #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
        .SEL_W(SW), .OWN_W(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .mReq_(mReq_), .mGrnt_(mGrnt_), .mAddr(mAddr),
        .mAs_(mAs_), .mRW(mRW), .mWrData(mWrData), .mRdData(mRdData), .mRdy_(mRdy_),
        .sAddr(sAddr), .sAs_(sAs_), .sRW(sRW), .sWrData(sWrData), .sCS_(sCS_),
        .sRdData(sRdData), .sRdy_(sRdy_), .owner(owner), .busy(busy), .busErr(busErr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NM-1:0] gq[$];     // expected grant vectors
    logic [DW:0]   sb_q[$];   // expected {mRdy_, mRdData}
    int            ord_q[$];  // expected grant order

    function automatic int rr_pick(int base, logic [NM-1:0] rq, int excl);
        for (int k = 1; k <= NM; k++) begin
            int c = (base + k) % NM;
            if (!rq[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        mReq_ = '1; mAs_ = '1; mRW = '1; mAddr = '0; mWrData = '0;
        sRdData = '0; sRdy_ = '1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        // a master drives the bus lines without requesting: nothing may leak through
        mAddr[1*AW +: AW] = 30'h2000_0004; mAs_[1] = 1'b0; mRW[1] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (mGrnt_ !== 4'hF) begin n_bad++; $display("FAIL reset_grant: got %b want 1111", mGrnt_); end
        n_cmp++; if (sCS_ !== 8'hFF) begin n_bad++; $display("FAIL reset_cs: got %b want 11111111", sCS_); end
        n_cmp++; if (sAs_ !== 1'b1 || sRW !== 1'b1) begin n_bad++; $display("FAIL reset_as_rw: got %b%b want 11", sAs_, sRW); end
        n_cmp++; if (mRdy_ !== 1'b1 || mRdData !== 32'h0) begin n_bad++; $display("FAIL reset_rdy: got %b %h want 1 0", mRdy_, mRdData); end
        n_cmp++; if (busy !== 1'b0 || owner !== 2'd0 || busErr !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b %0d %b want 0 0 0", busy, owner, busErr); end
        n_cmp++; if (sAddr !== 30'h0 || sWrData !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h %h want 0 0", sAddr, sWrData); end
    endtask

    task automatic test_single_grant();
        do_reset();
        mReq_[1] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (mGrnt_ !== 4'b1101 || owner !== 2'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL grant_m1: got %b own %0d busy %b want 1101 own 1 busy 1", mGrnt_, owner, busy); end
        @(negedge clk);
        mAddr[1*AW +: AW] = 30'h2000_0004; mAs_[1] = 1'b0; mRW[1] = 1'b0;
        mWrData[1*DW +: DW] = 32'hDEAD_BEEF;
        mAddr[0*AW +: AW] = 30'h0800_0000; mAs_[0] = 1'b0;
        #1;
        n_cmp++; if (sCS_ !== 8'b1110_1111) begin n_bad++; $display("FAIL decode_cs: got %b want 11101111", sCS_); end
        n_cmp++; if (sAddr !== 30'h2000_0004 || sAs_ !== 1'b0) begin n_bad++; $display("FAIL share_addr: got %h %b want 20000004 0", sAddr, sAs_); end
        n_cmp++; if (sRW !== 1'b0 || sWrData !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL share_wr: got %b %h want 0 deadbeef", sRW, sWrData); end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (mGrnt_ !== 4'hF || busy !== 1'b0 || sCS_ !== 8'hFF) begin n_bad++; $display("FAIL async_reset: got %b %b %b want 1111 0 ff", mGrnt_, busy, sCS_); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_handover();
        do_reset();
        mReq_ = 4'b0110;
        @(posedge clk); #1;
        n_cmp++; if (mGrnt_ !== 4'b1110) begin n_bad++; $display("FAIL hand_first: got %b want 1110", mGrnt_); end
        @(negedge clk); mReq_ = 4'b0111;
        @(posedge clk); #1;
        n_cmp++; if (mGrnt_ !== 4'b0111 || owner !== 2'd3) begin n_bad++; $display("FAIL hand_direct: got %b own %0d want 0111 own 3", mGrnt_, owner); end
        @(negedge clk); mReq_ = 4'b1111;
        @(posedge clk); #1;
        n_cmp++; if (mGrnt_ !== 4'b1111 || busy !== 1'b0) begin n_bad++; $display("FAIL hand_idle: got %b busy %b want 1111 0", mGrnt_, busy); end
        @(negedge clk); mReq_ = 4'b1110;
        @(posedge clk); #1;
        n_cmp++; if (mGrnt_ !== 4'b1110) begin n_bad++; $display("FAIL idle_m0: got %b want 1110", mGrnt_); end
        @(negedge clk); mReq_ = 4'b1111;
        @(posedge clk);
        @(negedge clk); mReq_ = 4'b0110;  // last owner 0: master 3 ahead of master 0
        @(posedge clk); #1;
        n_cmp++; if (mGrnt_ !== 4'b0111) begin n_bad++; $display("FAIL idle_rr: got %b want 0111", mGrnt_); end
        @(negedge clk); mReq_ = '1;
    endtask

    task automatic test_round_robin();
        int held, cur, got, want;
        logic [NM-1:0] prev_g;
        do_reset();
        ord_q = '{0, 1, 2, 3, 0};
        mReq_ = '0;
        prev_g = '1; held = 0; cur = -1;
        for (int cyc = 0; cyc < 40 && ord_q.size() > 0; cyc++) begin
            @(posedge clk); #1;
            n_cmp++; if ($countones(~mGrnt_) > 1) begin n_bad++; $display("FAIL rr_onehot: got %b want at most one low", mGrnt_); end
            if (mGrnt_ !== prev_g && mGrnt_ !== 4'hF) begin
                got = -1;
                for (int i = 0; i < NM; i++) if (!mGrnt_[i]) got = i;
                want = ord_q.pop_front();
                n_cmp++; if (got != want) begin n_bad++; $display("FAIL rr_order: got %0d want %0d", got, want); end
                cur = got; held = 1;
            end else if (cur >= 0) begin
                held++;
            end
            prev_g = mGrnt_;
            @(negedge clk);
            mReq_ = '0;
            if (held == 3) mReq_[cur] = 1'b1;
        end
        n_cmp++; if (ord_q.size() != 0) begin n_bad++; $display("FAIL rr_timeout: got %0d grants missing want 0", ord_q.size()); end
        mReq_ = '1;
    endtask

    task automatic test_random_arb();
        int m_busy, m_owner, m_last, w;
        logic [NM-1:0] rq, e;
        do_reset();
        m_busy = 0; m_owner = 0; m_last = NM - 1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            rq = NM'($urandom);
            if (m_busy != 0 && $urandom_range(3, 0) != 0) rq[m_owner] = 1'b0;
            mReq_ = rq;
            if (m_busy == 0) begin
                w = rr_pick(m_last, rq, -1);
                if (w >= 0) begin m_busy = 1; m_owner = w; end
            end else if (rq[m_owner]) begin
                m_last = m_owner;
                w = rr_pick(m_owner, rq, m_owner);
                if (w >= 0) m_owner = w;
                else begin m_busy = 0; m_owner = 0; end
            end
            e = '1;
            if (m_busy != 0) e[m_owner] = 1'b0;
            gq.push_back(e);
            @(posedge clk); #1;
            e = gq.pop_front();
            n_cmp++; if (mGrnt_ !== e) begin n_bad++; $display("FAIL rand_grant: cycle %0d got %b want %b", cyc, mGrnt_, e); end
            @(negedge clk);
        end
        mReq_ = '1;
    endtask

    task automatic test_read_return();
        logic [SW-1:0] idxs [3] = '{3'd4, 3'd2, 3'd4};
        logic          rdyn [3] = '{1'b0, 1'b0, 1'b1};
        logic [DW:0]   e;
        logic [NS-1:0] cs_exp;
        do_reset();
        for (int j = 0; j < NS; j++) sRdData[j*DW +: DW] = 32'h100 + j;
        sRdData[4*DW +: DW] = 32'h0000_00A5;
        mReq_[2] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (mGrnt_ !== 4'b1011) begin n_bad++; $display("FAIL rd_grant: got %b want 1011", mGrnt_); end
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            mAddr[2*AW +: AW] = {idxs[t], 27'h10}; mAs_[2] = 1'b0; mRW[2] = 1'b1;
            sRdy_ = '1; sRdy_[idxs[t]] = rdyn[t];
            sb_q.push_back({rdyn[t], (idxs[t] == 3'd4) ? 32'h0000_00A5 : 32'h100 + 32'(idxs[t])});
            #1;
            e = sb_q.pop_front();
            n_cmp++; if ({mRdy_, mRdData} !== e) begin n_bad++; $display("FAIL rd_return%0d: got %b %h want %b %h", t, mRdy_, mRdData, e[DW], e[DW-1:0]); end
            cs_exp = '1; cs_exp[idxs[t]] = 1'b0;
            n_cmp++; if (sCS_ !== cs_exp || sRW !== 1'b1) begin n_bad++; $display("FAIL rd_cs%0d: got %b %b want %b 1", t, sCS_, sRW, cs_exp); end
        end
        @(negedge clk); mReq_[2] = 1'b1; sRdy_ = '0;
        @(posedge clk); #1;
        n_cmp++; if (mRdy_ !== 1'b1 || mRdData !== 32'h0 || sCS_ !== 8'hFF) begin n_bad++; $display("FAIL rd_idle: got %b %h %b want 1 0 ff", mRdy_, mRdData, sCS_); end
        @(negedge clk); sRdy_ = '1;
    endtask

    task automatic test_timeout();
        int first, lows, errs;
        do_reset();
        mReq_[0] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (mGrnt_ !== 4'b1110) begin n_bad++; $display("FAIL to_grant: got %b want 1110", mGrnt_); end
        @(negedge clk);
        mAddr[0*AW +: AW] = {3'd5, 27'h0}; mAs_[0] = 1'b0; mRW[0] = 1'b1;
        for (int j = 0; j < NS; j++) sRdData[j*DW +: DW] = 32'h200 + j;
        first = -1; lows = 0; errs = 0;
`ifdef BUS_TIMEOUT_EN
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (busErr === 1'b1) errs++;
            if (mRdy_ !== 1'b1) begin
                lows++;
                if (first < 0) first = c;
                n_cmp++; if (mRdData !== 32'hFFFF_FFFF || busErr !== 1'b1) begin n_bad++; $display("FAIL to_force: got %h %b want ffffffff 1", mRdData, busErr); end
            end
        end
        n_cmp++; if (first != TO) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", first, TO); end
        n_cmp++; if (lows != 1 || errs != 1) begin n_bad++; $display("FAIL to_pulse: got %0d/%0d want 1/1", lows, errs); end
`else
        for (int c = 1; c <= 1100; c++) begin
            @(posedge clk); #1;
            if (mRdy_ !== 1'b1) lows++;
            if (busErr !== 1'b0) errs++;
        end
        n_cmp++; if (lows != 0 || errs != 0) begin n_bad++; $display("FAIL to_stall: got %0d/%0d want 0/0", lows, errs); end
        n_cmp++; if (mRdData !== 32'h205 || sCS_ !== 8'b1101_1111) begin n_bad++; $display("FAIL to_hold: got %h %b want 205 11011111", mRdData, sCS_); end
`endif
        @(negedge clk); mReq_ = '1; mAs_ = '1;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_grant();
        test_handover();
        test_round_robin();
        test_random_arb();
        test_read_return();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
